// File: rtl/serial_adder.sv
// Bit-serial two's-complement adder/subtractor: one full-adder cell reused over
// WIDTH cycles, LSB first, with valid/ready handshakes on input and output.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-2:0]   acc_q, acc_d;
  logic               c_q, c_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_out_q, carry_out_d;
  logic               overflow_q, overflow_d;
  logic               s_bit;
  logic               c_next;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    c_d         = c_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    s_bit       = a_q[0] ^ b_q[0] ^ c_q;
    c_next      = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Subtraction is A + ~B + 1: the +1 enters as the initial carry.
          a_d     = a;
          b_d     = mode ? ~b : b;
          c_d     = mode;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = c_next;
        acc_d = (WIDTH-1)'({s_bit, acc_q} >> 1);
        if (cnt_q == LAST) begin
          // On the MSB step c_q is the carry into the MSB.
          sum_d       = {s_bit, acc_q};
          carry_out_d = c_next;
          overflow_d  = c_q ^ c_next;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      c_q         <= 1'b0;
      cnt_q       <= '0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      c_q         <= c_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial, parametrised two's-complement adder/subtractor. It reuses a single full-adder cell (sum = a^b^c, carry = majority) over WIDTH cycles instead of building a parallel adder. It sits behind the tile's dedicated inputs as the next-generation arithmetic cell after the half adder. It adds operand width, subtract mode, carry/overflow flags and a valid/ready handshake on both sides.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair and mode are valid.
- in_ready  out  1  block can accept operands; high only in IDLE.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- mode  in  1  0 = A+B, 1 = A−B.
- out_valid  out  1  result is valid; high only in DONE.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- carry_out  out  1  carry out of the MSB. In subtract mode, 1 means no borrow.
- overflow  out  1  signed overflow: carry into MSB XOR carry out of MSB.
- busy  out  1  high in RUN.

## Operation
- Reset is asynchronous and active-high, with the same semantics whether the block is idle or mid-operation. While rst is high:
  - state = IDLE; internal operand, sum and bit-counter registers cleared.
  - in_ready = 1, out_valid = 0, busy = 0, sum = 0, carry_out = 0, overflow = 0.
  - Mid-operation: the operation in flight is discarded and no result is produced.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, latch a into the A shift register.
  - Latch b (mode=0) or ~b (mode=1) into the B shift register.
  - carry register <= mode; bit counter <= 0; go to RUN.
- RUN, one bit per cycle, LSB first:
  - s = A[0]^B[0]^c; c <= majority(A[0],B[0],c).
  - Shift A and B right by one; shift s into the MSB of the sum register.
  - Before the MSB step, latch the current c as carry-into-MSB.
  - When the counter reaches WIDTH−1, perform the MSB step and go to DONE.
  - in_valid is ignored in RUN.
- DONE:
  - out_valid = 1; sum, carry_out and overflow are held stable until the handshake.
  - On out_valid & out_ready, go to IDLE.
  - in_ready stays 0 in DONE; there is no same-cycle accept of a new operand.
- sum, carry_out and overflow keep their last values after returning to IDLE. They change only at the final RUN step of the next operation.
- Arithmetic is exactly {carry_out, sum} = a + (mode ? ~b : b) + mode, truncated to WIDTH+1 bits.
- Counter width is $clog2(WIDTH). The counter never wraps inside an operation.

## Timing
- Accept edge = E0. RUN steps occur on edges E1..E_WIDTH.
- out_valid is high after edge E_WIDTH, i.e. WIDTH cycles of latency from acceptance.
- If out_ready is high when out_valid rises: handshake completes on edge E_WIDTH+1, and in_ready is high after it.
- Minimum initiation interval is WIDTH+2 cycles.
- Backpressure: out_valid and the result stay constant for any number of cycles while out_ready = 0.
- in_ready, out_valid and busy are decoded from registered state only; there is no combinational path from any input to any output.
- rst asserted on any cycle forces outputs to their reset values immediately, without waiting for an edge.

## Test plan
- WIDTH=8, mode=0, a=0x0F, b=0x01 -> after 8 cycles out_valid=1, sum=0x10, carry_out=0, overflow=0.
- WIDTH=8, mode=0, a=0xFF, b=0x01 -> sum=0x00, carry_out=1, overflow=0. Then a=0x7F, b=0x01 -> sum=0x80, carry_out=0, overflow=1.
- WIDTH=8, mode=1, a=0x05, b=0x07 -> sum=0xFE, carry_out=0 (borrow), overflow=0. Then a=0x80, b=0x01 -> sum=0x7F, carry_out=1, overflow=1.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles after out_valid rises, while in_valid=1 with new operands.
  - Required: sum and flags unchanged, in_ready=0, new operands ignored.
  - Required: the new operands are accepted only in the cycle after the handshake.
- Reset mid-operation:
  - Stimulus: assert rst on the 3rd RUN cycle, then release it.
  - Required: out_valid stays 0, in_ready=1, sum=0, and busy drops without waiting for a clock edge.
  - Required: a fresh operation afterwards (0x12+0x34) gives 0x46.
- WIDTH=16 and WIDTH=2 builds:
  - 16-bit: 0xFFFF+0x0001 -> sum=0x0000, carry_out=1, latency 16 cycles.
  - 2-bit: 0b01+0b01 -> sum=0b10, overflow=1, latency 2 cycles.
